// File: rtl/waveform_pkg.sv
// rtl/waveform_pkg.sv - waveform select encodings and quarter-sine table
package waveform_pkg;

  localparam logic [2:0] FUNC_SAW_UP   = 3'b000;
  localparam logic [2:0] FUNC_SQUARE   = 3'b001;
  localparam logic [2:0] FUNC_TRIANGLE = 3'b010;
  localparam logic [2:0] FUNC_SINE     = 3'b011;
  localparam logic [2:0] FUNC_FULL_REC = 3'b100;
  localparam logic [2:0] FUNC_HALF_REC = 3'b101;
  localparam logic [2:0] FUNC_RECIP    = 3'b110;
  localparam logic [2:0] FUNC_SAW_DN   = 3'b111;

  // T[k] = round(255*sin(pi*k/256)), k = 0..128
  localparam logic [7:0] SINE_T [0:128] = '{
    8'd0,   8'd3,   8'd6,   8'd9,   8'd13,  8'd16,  8'd19,  8'd22,
    8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd41,  8'd44,  8'd47,
    8'd50,  8'd53,  8'd56,  8'd59,  8'd62,  8'd65,  8'd68,  8'd71,
    8'd74,  8'd77,  8'd80,  8'd83,  8'd86,  8'd89,  8'd92,  8'd95,
    8'd98,  8'd100, 8'd103, 8'd106, 8'd109, 8'd112, 8'd115, 8'd117,
    8'd120, 8'd123, 8'd126, 8'd128, 8'd131, 8'd134, 8'd136, 8'd139,
    8'd142, 8'd144, 8'd147, 8'd149, 8'd152, 8'd154, 8'd157, 8'd159,
    8'd162, 8'd164, 8'd167, 8'd169, 8'd171, 8'd174, 8'd176, 8'd178,
    8'd180, 8'd183, 8'd185, 8'd187, 8'd189, 8'd191, 8'd193, 8'd195,
    8'd197, 8'd199, 8'd201, 8'd203, 8'd205, 8'd207, 8'd208, 8'd210,
    8'd212, 8'd214, 8'd215, 8'd217, 8'd219, 8'd220, 8'd222, 8'd223,
    8'd225, 8'd226, 8'd228, 8'd229, 8'd231, 8'd232, 8'd233, 8'd234,
    8'd236, 8'd237, 8'd238, 8'd239, 8'd240, 8'd241, 8'd242, 8'd243,
    8'd244, 8'd245, 8'd246, 8'd247, 8'd247, 8'd248, 8'd249, 8'd249,
    8'd250, 8'd251, 8'd251, 8'd252, 8'd252, 8'd253, 8'd253, 8'd253,
    8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
    8'd255
  };

endpackage

// File: rtl/sine_rom.sv
// rtl/sine_rom.sv - half-period sine lookup with mirroring above index 128
module sine_rom
  import waveform_pkg::*;
(
  input  logic [8:0] idx_i,
  output logic [7:0] t_o
);

  logic [8:0] k;

  // Fold indices 129..256 back onto 127..0; anything beyond 256 reads as 0
  always_comb begin
    k   = (idx_i > 9'd128) ? (9'd256 - idx_i) : idx_i;
    t_o = (k <= 9'd128) ? SINE_T[k[7:0]] : 8'd0;
  end

endmodule

// File: rtl/waveform_generator.sv
// rtl/waveform_generator.sv - phase accumulator, waveform mux and output register
module waveform_generator
  import waveform_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] func,
  output logic [7:0] wave
);

  logic [7:0] p_q, p_d;
  logic [7:0] wave_q, wave_d;
  logic [8:0] rom_idx;
  logic [7:0] rom_t;

  sine_rom u_sine_rom (
    .idx_i (rom_idx),
    .t_o   (rom_t)
  );

  // Sine and half-rectified both walk the table at twice the phase rate
  // ({p[6:0],0} = 2p for the first half, 2(p-128) for the second);
  // full-rectified walks it at the phase rate.
  always_comb begin
    rom_idx = {1'b0, p_q[6:0], 1'b0};
    if (func == FUNC_FULL_REC) rom_idx = {1'b0, p_q};
  end

  // Waveform selection; every branch stays within 0..255 by construction
  always_comb begin
    p_d    = p_q + 8'd1;
    wave_d = 8'd0;
    case (func)
      FUNC_SAW_UP:   wave_d = p_q;
      FUNC_SQUARE:   wave_d = p_q[7] ? 8'd0 : 8'd255;
      FUNC_TRIANGLE: wave_d = p_q[7] ? {~p_q[6:0], 1'b0} : {p_q[6:0], 1'b0};
      FUNC_SINE:     wave_d = p_q[7] ? (8'd127 - {1'b0, rom_t[7:1]})
                                     : (8'd128 + {1'b0, rom_t[7:1]});
      FUNC_FULL_REC: wave_d = rom_t;
      FUNC_HALF_REC: wave_d = p_q[7] ? 8'd0 : rom_t;
      FUNC_RECIP:    wave_d = 8'(9'd255 / ({1'b0, p_q} + 9'd1));
      FUNC_SAW_DN:   wave_d = 8'd255 - p_q;
      default:       wave_d = 8'd0;
    endcase
  end

  // Phase and sample registers; reset wins over the increment
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= 8'd0;
      wave_q <= 8'd0;
    end else begin
      p_q    <= p_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: tb/tb_waveform_generator.sv
// tb/tb_waveform_generator.sv - randomized and directed bench against a reference model
module tb_waveform_generator;

  logic       clk;
  logic       rst;
  logic [2:0] func;
  logic [7:0] wave;

  int total = 0;
  int bad   = 0;
  int p_m   = 0;

  // Spot values (func, phase, sample) taken straight from the waveform definitions
  int dir_f [23] = '{3, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 5, 6, 6, 6, 6, 7, 7, 2, 2, 0, 1, 1};
  int dir_p [23] = '{0, 64, 128, 192, 0, 64, 128, 192, 0, 64, 128, 192, 0, 1, 2, 255, 0, 255, 127, 128, 255, 127, 128};
  int dir_v [23] = '{128, 255, 127, 0, 0, 180, 255, 180, 0, 255, 0, 0, 255, 127, 85, 0, 255, 0, 254, 254, 255, 255, 0};

  waveform_generator dut (
    .clk  (clk),
    .rst  (rst),
    .func (func),
    .wave (wave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    total++;
    if (obs != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int t_ref(input int k);
    int  kk;
    real r;
    kk = (k > 128) ? 256 - k : k;
    r  = 255.0 * $sin(3.14159265358979323846 * kk / 256.0);
    return $rtoi(r + 0.5);
  endfunction

  function automatic int f_ref(input int f, input int p);
    case (f)
      0: return p;
      1: return (p < 128) ? 255 : 0;
      2: return (p < 128) ? 2 * p : 2 * (255 - p);
      3: return (p < 128) ? 128 + t_ref(2 * p) / 2 : 127 - t_ref(2 * (p - 128)) / 2;
      4: return t_ref(p);
      5: return (p < 128) ? t_ref(2 * p) : 0;
      6: return 255 / (p + 1);
      default: return 255 - p;
    endcase
  endfunction

  task automatic step(input logic r, input logic [2:0] f);
    int exp_v;
    rst  = r;
    func = f;
    @(posedge clk);
    #1;
    if (r) begin
      exp_v = 0;
      p_m   = 0;
    end else begin
      exp_v = f_ref(int'(f), p_m);
      for (int i = 0; i < 23; i++)
        if (dir_f[i] == int'(f) && dir_p[i] == p_m)
          check("spot", int'(wave), dir_v[i]);
      p_m = (p_m + 1) % 256;
    end
    check(r ? "reset" : "wave", int'(wave), exp_v);
  endtask

  initial begin
    rst  = 1'b1;
    func = 3'd0;

    repeat (3) step(1'b1, 3'd0);
    repeat (300) step(1'b0, 3'd0);
    repeat (512) step(1'b0, 3'd1);

    step(1'b1, 3'd2);
    for (int f = 2; f < 8; f++)
      repeat (256) step(1'b0, 3'(f));

    repeat (2000) step($urandom_range(0, 63) == 0, 3'($urandom_range(0, 7)));

    for (int f = 0; f < 8; f++)
      repeat (2500) step(1'b0, 3'(f));

    repeat (37) step(1'b0, 3'd3);
    step(1'b1, 3'd3);
    step(1'b0, 3'd0);
    check("restart", int'(wave), 0);
    step(1'b0, 3'd0);
    check("restart+1", int'(wave), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
